uart_tx_fifo: RTL and testbench

Buffered UART transmitter: accepts parallel words through a valid/ready handshake into an internal FIFO, then serialises them onto o_TX as start, data (LSB first), optional even parity, and stop bit(s). Bit timing is paced by the one-cycle-per-bit-period tick from uart_baudgen (o_baud). It lets a producer burst up to FIFO_DEPTH words without waiting per frame. Frames are compatible with the existing uart_rx configured with the same DATA_WIDTH/PARITY_EN.

---
 rtl/uart_tx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a valid/ready FIFO feeding a baud-paced serialiser
// (start, LSB-first data, optional even parity, one or two stop bits).
module uart_tx_fifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int PARITY_EN       = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_baud,
    input  logic [DATA_WIDTH-1:0]      i_din,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [FIFO_DEPTH_LOG2:0]   o_count,
    output logic                       o_busy,
    output logic                       o_TX
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]           FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]           ZERO_COUNT = {CNT_W{1'b0}};
    localparam logic [BIT_W-1:0]           LAST_BIT   = BIT_W'(DATA_WIDTH - 1);
    localparam logic                       LAST_STOP  = 1'(STOP_BITS - 1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);
    localparam logic [CNT_W-1:0]           CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        even_parity = ^d;
    endfunction

    logic [DATA_WIDTH-1:0]      mem_r [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    state_t                     state_r;
    logic [DATA_WIDTH-1:0]      shift_r;
    logic                       par_r;
    logic [BIT_W-1:0]           bit_cnt_r;
    logic                       stop_cnt_r;
    logic                       tx_r;
    logic                       push_s;
    logic                       pop_s;
    logic                       not_empty_s;
    logic [DATA_WIDTH-1:0]      head_s;

    assign o_ready = (count_r != FULL_COUNT);
    assign o_count = count_r;
    assign o_busy  = (state_r != IDLE) || (count_r != ZERO_COUNT);
    assign o_TX    = tx_r;
    assign head_s  = mem_r[rd_ptr_r];

    // Handshake and pop decode; a pop only ever happens on a baud tick with data waiting.
    always_comb begin
        push_s      = i_valid && o_ready;
        not_empty_s = (count_r != ZERO_COUNT);
        pop_s       = 1'b0;
        case (state_r)
            IDLE:    pop_s = i_baud && not_empty_s;
            STOP:    pop_s = i_baud && not_empty_s && (stop_cnt_r == LAST_STOP);
            default: pop_s = 1'b0;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= i_din;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
            count_r  <= ZERO_COUNT;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame serialiser; the line level is registered and only changes on baud ticks.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_r    <= IDLE;
            shift_r    <= {DATA_WIDTH{1'b0}};
            par_r      <= 1'b0;
            bit_cnt_r  <= {BIT_W{1'b0}};
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
        end else if (i_baud) begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        shift_r <= head_s;
                        par_r   <= even_parity(head_s);
                        tx_r    <= 1'b0;
                        state_r <= START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                START: begin
                    tx_r      <= shift_r[0];
                    shift_r   <= shift_r >> 1;
                    bit_cnt_r <= {BIT_W{1'b0}};
                    state_r   <= DATA;
                end
                DATA: begin
                    if (bit_cnt_r != LAST_BIT) begin
                        tx_r      <= shift_r[0];
                        shift_r   <= shift_r >> 1;
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end else if (PARITY_EN != 0) begin
                        tx_r    <= par_r;
                        state_r <= PARITY;
                    end else begin
                        tx_r       <= 1'b1;
                        stop_cnt_r <= 1'b0;
                        state_r    <= STOP;
                    end
                end
                PARITY: begin
                    tx_r       <= 1'b1;
                    stop_cnt_r <= 1'b0;
                    state_r    <= STOP;
                end
                STOP: begin
                    if (stop_cnt_r != LAST_STOP) begin
                        stop_cnt_r <= 1'b1;
                    end else if (pop_s) begin
                        // Back-to-back frame: next start bit follows the last stop bit directly.
                        shift_r <= head_s;
                        par_r   <= even_parity(head_s);
                        tx_r    <= 1'b0;
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (default framing, and parity with two stop bits)
// share stimulus; a line decoder per instance checks frames against a word scoreboard.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       baud = 1'b0;
    logic [7:0] din = 8'h00;
    logic       valid = 1'b0;
    logic       ready0, busy0, tx0, ready1, busy1, tx1;
    logic [4:0] count0, count1;

    always #5 clk = ~clk;

    uart_tx_fifo u_dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_baud(baud), .i_din(din), .i_valid(valid),
        .o_ready(ready0), .o_count(count0), .o_busy(busy0), .o_TX(tx0)
    );

    uart_tx_fifo #(.PARITY_EN(1), .STOP_BITS(2)) u_dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_baud(baud), .i_din(din), .i_valid(valid),
        .o_ready(ready1), .o_count(count1), .o_busy(busy1), .o_TX(tx1)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         pos[2] = '{0, 0};
    logic [7:0] rx_data[2];
    int         frames[2] = '{0, 0};
    int         idle_pend[2] = '{0, 0};
    logic       rx_par = 1'b0;
    logic [9:0] log_seq = 10'd0;
    int         log_n = 0;

    typedef struct {
        logic [7:0] din;
        logic       par;
        logic       seq_chk;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decode one baud-period line level of instance d.
    task automatic rx_step(input int d, input logic b);
        int         len;
        logic [7:0] exp_w;
        len = (d == 1) ? 12 : 10;
        if (pos[d] == 0) begin
            if (b == 1'b0) begin
                pos[d] = 1;
            end else if ((d == 0) ? (q0.size() != 0) : (q1.size() != 0)) begin
                idle_pend[d]++;
            end
        end else begin
            if (pos[d] <= 8) begin
                rx_data[d][pos[d]-1] = b;
            end else if (d == 1 && pos[d] == 9) begin
                rx_par = b;
                check("parity_vs_data", {31'd0, b}, {31'd0, ^rx_data[d]});
            end else begin
                check($sformatf("stop_bit%0d", d), {31'd0, b}, 32'd1);
            end
            if (pos[d] == len - 1) begin
                if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                    check($sformatf("unexpected_frame%0d", d), {24'd0, rx_data[d]}, 32'hFFFF_FFFF);
                end else begin
                    exp_w = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("frame_data%0d", d), {24'd0, rx_data[d]}, {24'd0, exp_w});
                end
                frames[d]++;
                pos[d] = 0;
            end else begin
                pos[d]++;
            end
        end
    endtask

    task automatic sample();
        if (log_n < 10) begin
            log_seq[log_n] = tx0;
            log_n++;
        end
        rx_step(0, tx0);
        rx_step(1, tx1);
    endtask

    // Hold i_baud high for n consecutive cycles, decoding the line after each tick.
    task automatic tick(input int n);
        @(negedge clk);
        baud = 1'b1;
        repeat (n) begin
            @(negedge clk);
            sample();
        end
        baud = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] w);
        @(negedge clk);
        din   = w;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        q0.push_back(w);
        q1.push_back(w);
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || pos[0] != 0 || pos[1] != 0) && k < bound) begin
            tick(3);
            k++;
        end
        check("drain_timeout", {31'd0, (q0.size() != 0 || q1.size() != 0)}, 32'd0);
    endtask

    vec_t vecs[5];
    int   f0, f1;

    initial begin
        vecs[0] = '{din: 8'hA6, par: 1'b0, seq_chk: 1'b1};
        vecs[1] = '{din: 8'h37, par: 1'b1, seq_chk: 1'b0};
        vecs[2] = '{din: 8'h00, par: 1'b0, seq_chk: 1'b0};
        vecs[3] = '{din: 8'hFF, par: 1'b0, seq_chk: 1'b0};
        vecs[4] = '{din: 8'h3C, par: 1'b0, seq_chk: 1'b0};

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        check("rst_tx", {31'd0, tx0}, 32'd1);
        check("rst_ready", {31'd0, ready0}, 32'd1);
        check("rst_count", {27'd0, count0}, 32'd0);
        check("rst_busy", {31'd0, busy1}, 32'd0);

        // Single words from the table, one frame each.
        for (int i = 0; i < 5; i++) begin
            f0 = frames[0];
            f1 = frames[1];
            write_word(vecs[i].din);
            check("count_after_write", {27'd0, count0}, 32'd1);
            check("busy_after_write", {31'd0, busy0}, 32'd1);
            log_n = 0;
            tick(1);
            check("count_after_pop", {27'd0, count0}, 32'd0);
            check("start_bit", {31'd0, tx0}, 32'd0);
            drain(100);
            check("busy_after_frame0", {31'd0, busy0}, 32'd0);
            check("busy_after_frame1", {31'd0, busy1}, 32'd0);
            check("frames0", frames[0], f0 + 1);
            check("frames1", frames[1], f1 + 1);
            check("parity_bit", {31'd0, rx_par}, {31'd0, vecs[i].par});
            if (vecs[i].seq_chk) begin
                check("line_seq_A6", {22'd0, log_seq}, {22'd0, 10'b1101001100});
            end
        end

        // Write on the same cycle as a tick: that tick must not start the frame.
        @(negedge clk);
        din = 8'h81; valid = 1'b1; baud = 1'b1;
        @(negedge clk);
        valid = 1'b0; baud = 1'b0;
        q0.push_back(8'h81); q1.push_back(8'h81);
        sample();
        check("latency_tx_idle", {31'd0, tx0}, 32'd1);
        check("latency_count", {27'd0, count1}, 32'd1);
        tick(1);
        check("latency_start", {31'd0, tx0}, 32'd0);
        drain(100);

        // Two frames back to back; the 2-stop instance must show both stop periods.
        f1 = frames[1];
        idle_pend = '{0, 0};
        write_word(8'h55);
        write_word(8'h55);
        drain(100);
        check("two_frames", frames[1], f1 + 2);
        check("b2b_gap1", idle_pend[1], 0);

        // Push on the pop tick with three words queued.
        write_word(8'h11); write_word(8'h22); write_word(8'h33);
        check("coll_count_before", {27'd0, count0}, 32'd3);
        @(negedge clk);
        din = 8'h44; valid = 1'b1; baud = 1'b1;
        @(negedge clk);
        valid = 1'b0; baud = 1'b0;
        q0.push_back(8'h44); q1.push_back(8'h44);
        sample();
        check("coll_count0", {27'd0, count0}, 32'd3);
        check("coll_count1", {27'd0, count1}, 32'd3);
        drain(200);

        // Burst of 17 with baud low: the 17th waits for the first pop.
        idle_pend = '{0, 0};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("burst_ready", {31'd0, ready0}, 32'd1);
            din = 8'h10 + 8'(i);
            valid = 1'b1;
            q0.push_back(din); q1.push_back(din);
        end
        @(negedge clk);
        din = 8'h99;
        check("full_ready0", {31'd0, ready0}, 32'd0);
        check("full_ready1", {31'd0, ready1}, 32'd0);
        check("full_count", {27'd0, count0}, 32'd16);
        @(negedge clk);
        check("full_hold_count", {27'd0, count1}, 32'd16);
        tick(1);
        check("after_pop_count", {27'd0, count0}, 32'd15);
        check("after_pop_ready", {31'd0, ready0}, 32'd1);
        q0.push_back(8'h99); q1.push_back(8'h99);
        @(negedge clk);
        valid = 1'b0;
        check("refill_count", {27'd0, count0}, 32'd16);
        drain(300);
        check("burst_gap0", idle_pend[0], 0);
        check("burst_gap1", idle_pend[1], 0);

        // Reset during data bit 4 of 0xA5 with 0x77 still queued, then send 0x3C.
        write_word(8'hA5);
        write_word(8'h77);
        tick(1);
        tick(5);
        check("mid_bit4", {31'd0, tx0}, 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mid_tx0", {31'd0, tx0}, 32'd1);
        check("rst_mid_tx1", {31'd0, tx1}, 32'd1);
        check("rst_mid_count", {27'd0, count0}, 32'd0);
        check("rst_mid_busy", {31'd0, busy0}, 32'd0);
        rstn = 1'b1;
        q0.delete(); q1.delete();
        pos = '{0, 0};
        f0 = frames[0];
        write_word(8'h3C);
        drain(100);
        check("post_rst_frame", frames[0], f0 + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
